xor_resp_checker: RTL
=====================

XOR_RESP_CHECKER -- requirements
Module: xor_resp_checker

Interface
REQ-001 Parameter SETTLE_CYC, default 2: cycles from vector capture to f53 sample; legal range 1..15.
REQ-002 Parameter TIMEOUT_CYC, default 64: consecutive WAIT_VEC cycles without smp_valid before abort; legal range 1..255.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  synchronous, active-low reset, sampled on the rising clk edge.
REQ-005 start  in  1  begin a check session; sampled only in IDLE.
REQ-006 num_vec  in  8  vectors to check this session; captured at start.
REQ-007 smp_valid  in  1  a/b hold a new stimulus vector this cycle.
REQ-008 a  in  1  stimulus input A applied to the XOR under test.
REQ-009 b  in  1  stimulus input B applied to the XOR under test.
REQ-010 f53  in  1  XOR-under-test output.
REQ-011 busy  out  1  high in WAIT_VEC, SETTLE and CHECK.
REQ-012 done  out  1  single-cycle pulse at session end.
REQ-013 pass  out  1  session verdict; valid from the done cycle until the next accepted start.
REQ-014 timeout  out  1  session aborted on watchdog; valid with pass.
REQ-015 vec_cnt  out  8  vectors checked this session.
REQ-016 err_cnt  out  8  mismatches this session; saturates at 255.
REQ-017 cov  out  4  truth-table coverage; bit {a,b} set when that row has been checked.
REQ-018 first_err_vld  out  1  at least one mismatch recorded.
REQ-019 first_err_idx  out  8  vec_cnt value of the first mismatching vector.

Function
REQ-020 FSM states SHALL be IDLE, WAIT_VEC, SETTLE, CHECK and DONE.
REQ-021 IDLE with start=1 and num_vec!=0: at that edge latch num_vec, clear vec_cnt/err_cnt/cov/first_err_*/pass/timeout, go to WAIT_VEC.
REQ-022 IDLE with start=1 and num_vec==0: go to DONE with pass=0 and timeout=0.
REQ-023 start outside IDLE SHALL be ignored; num_vec changes after start SHALL be ignored.
REQ-024 WAIT_VEC with smp_valid=1: capture a,b into a_q,b_q, load settle counter with SETTLE_CYC-1, clear watchdog, go to SETTLE.
REQ-025 WAIT_VEC with smp_valid=0: increment watchdog; on reaching TIMEOUT_CYC go to DONE with timeout=1 and pass=0.
REQ-026 smp_valid outside WAIT_VEC SHALL be ignored and no vector captured.
REQ-027 SETTLE: decrement counter each cycle; at 0 go to CHECK. Capture-to-CHECK latency is SETTLE_CYC+1 cycles.
REQ-028 CHECK: compare f53 with a_q XOR b_q. At the edge: vec_cnt+=1; set cov[{a_q,b_q}].
REQ-029 CHECK on mismatch: err_cnt+=1, saturating at 255. On the first mismatch only: set first_err_vld and load first_err_idx with pre-increment vec_cnt.
REQ-030 CHECK next state: DONE if post-increment vec_cnt equals latched num_vec, else WAIT_VEC.
REQ-031 DONE on normal completion: pass = (err_cnt==0) and (cov==4'b1111), using post-update values.
REQ-032 DONE lasts exactly one cycle with done=1, then returns to IDLE.
REQ-033 All counters and status outputs SHALL hold their values in IDLE.
REQ-034 start in the DONE cycle SHALL be ignored.

Reset
REQ-035 rst_n=0 at any edge, including mid-session, SHALL force IDLE.
REQ-036 Reset SHALL clear busy, done, pass, timeout, vec_cnt, err_cnt, cov, first_err_vld, first_err_idx, a_q, b_q and all internal counters to 0 by the next edge.
REQ-037 No done pulse SHALL be generated for a session aborted by reset.

Verification
REQ-038 Correct XOR: num_vec=4, vectors 00,01,10,11 with f53=a^b -> done after the 4th CHECK; pass=1, err_cnt=0, cov=1111, vec_cnt=4.
REQ-039 Stuck-at-0 f53: same vectors -> err_cnt=2, first_err_vld=1, first_err_idx=1, pass=0.
REQ-040 Coverage hole: num_vec=3, vectors 00,01,10 all correct -> cov=0111, pass=0, err_cnt=0.
REQ-041 Watchdog: TIMEOUT_CYC=64, start with num_vec=4, one vector, then smp_valid held low -> done exactly 64 cycles after entering WAIT_VEC; timeout=1, pass=0, vec_cnt=1.
REQ-042 Boundary and robustness:
- start with num_vec=0 -> done next cycle, pass=0.
- start or smp_valid pulsed during SETTLE -> ignored.
- rst_n=0 for one cycle mid-SETTLE -> all outputs 0, no done pulse.
REQ-043 Saturation: num_vec=255 with f53 inverted -> err_cnt=255, vec_cnt=255, first_err_idx=0.

Source files
------------

// File: rtl/xor_resp_checker.sv
// Purpose: drives a check session over stimulus vectors and scores an XOR gate's f53 response against a^b.
// Latency: SETTLE_CYC+1 cycles from vector capture to the f53 sample; the verdict appears in the one-cycle done state.
// Backpressure: smp_valid is taken only while waiting for a vector; a watchdog aborts a session if no vector arrives.
module xor_resp_checker #(
    parameter int SETTLE_CYC  = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] num_vec,
    input  logic       smp_valid,
    input  logic       a,
    input  logic       b,
    input  logic       f53,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic       timeout,
    output logic [7:0] vec_cnt,
    output logic [7:0] err_cnt,
    output logic [3:0] cov,
    output logic       first_err_vld,
    output logic [7:0] first_err_idx
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_VEC,
        SETTLE,
        CHECK,
        DONE
    } state_t;

    // Settle counter counts down to 0, so it is loaded with one less than the settle time.
    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC - 1);
    // Watchdog fires on the edge where it would reach TIMEOUT_CYC.
    localparam logic [7:0] WD_LAST   = 8'(TIMEOUT_CYC - 1);

    state_t     state;
    logic [7:0] num_q;
    logic       a_q;
    logic       b_q;
    logic [3:0] settle_cnt;
    logic [7:0] wd_cnt;

    logic [7:0] vec_inc;
    logic       mism;
    logic [7:0] err_nxt;
    logic [3:0] cov_nxt;

    // Post-update values of the check step, shared by the counters and the final verdict.
    always_comb begin
        vec_inc = vec_cnt + 8'd1;
        mism    = (f53 != (a_q ^ b_q));
        err_nxt = err_cnt;
        if (mism && (err_cnt != 8'hFF)) begin
            err_nxt = err_cnt + 8'd1;
        end
        cov_nxt = cov | (4'b0001 << {a_q, b_q});
    end

    // Session state machine with registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            num_q         <= 8'd0;
            a_q           <= 1'b0;
            b_q           <= 1'b0;
            settle_cnt    <= 4'd0;
            wd_cnt        <= 8'd0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            timeout       <= 1'b0;
            vec_cnt       <= 8'd0;
            err_cnt       <= 8'd0;
            cov           <= 4'd0;
            first_err_vld <= 1'b0;
            first_err_idx <= 8'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (num_vec != 8'd0) begin
                            num_q         <= num_vec;
                            vec_cnt       <= 8'd0;
                            err_cnt       <= 8'd0;
                            cov           <= 4'd0;
                            first_err_vld <= 1'b0;
                            first_err_idx <= 8'd0;
                            pass          <= 1'b0;
                            timeout       <= 1'b0;
                            wd_cnt        <= 8'd0;
                            busy          <= 1'b1;
                            state         <= WAIT_VEC;
                        end else begin
                            // Empty session: report completion with a failing verdict.
                            pass    <= 1'b0;
                            timeout <= 1'b0;
                            done    <= 1'b1;
                            state   <= DONE;
                        end
                    end
                end
                WAIT_VEC: begin
                    if (smp_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        settle_cnt <= SETTLE_LD;
                        wd_cnt     <= 8'd0;
                        state      <= SETTLE;
                    end else if (wd_cnt == WD_LAST) begin
                        wd_cnt  <= 8'd0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                        pass    <= 1'b0;
                        state   <= DONE;
                    end else begin
                        wd_cnt <= wd_cnt + 8'd1;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == 4'd0) begin
                        state <= CHECK;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                CHECK: begin
                    vec_cnt <= vec_inc;
                    cov     <= cov_nxt;
                    err_cnt <= err_nxt;
                    // Index records the pre-increment count of the first failing vector.
                    if (mism && !first_err_vld) begin
                        first_err_vld <= 1'b1;
                        first_err_idx <= vec_cnt;
                    end
                    if (vec_inc == num_q) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        timeout <= 1'b0;
                        pass    <= (err_nxt == 8'd0) && (cov_nxt == 4'hF);
                        state   <= DONE;
                    end else begin
                        state <= WAIT_VEC;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
